// File: rtl/score_ctrl_pkg.sv
// Shared types, encodings and defaults for the frame-synchronous score controller.
package score_ctrl_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned PEND_W  = 2;

  localparam int unsigned WIN_SCORE_DEF   = 6;
  localparam int unsigned HOLD_FRAMES_DEF = 120;
  localparam int unsigned PEND_MAX_DEF    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WIN   = 2'd2
  } state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P0   = 2'b01;
  localparam logic [1:0] WINNER_P1   = 2'b10;

  // Increment a score but never past the winning value.
  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s,
                                                       input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? lim : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Produces a one-cycle frame tick on each falling edge of the active-low vsync.
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick_c
);

  logic vsync_q;

  // Delayed vsync; resets high so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b1;
    else        vsync_q <= vsync;
  end

  assign frame_tick_c = vsync_q & ~vsync;

endmodule

// File: rtl/score_frame_ctrl.sv
// Two-player score keeper that applies queued increments only at frame boundaries.
module score_frame_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int unsigned PEND_MAX    = PEND_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               inc0_req,
  input  logic               inc1_req,
  input  logic               clr_req,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [1:0]         winner,
  output logic               gnt0,
  output logic               gnt1,
  output logic               drop0,
  output logic               drop1
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES) + 1;
  localparam logic [SCORE_W-1:0] WIN_LIM  = SCORE_W'(WIN_SCORE);
  localparam logic [PEND_W-1:0]  PEND_LIM = PEND_W'(PEND_MAX);
  localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(HOLD_FRAMES - 1);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;
  logic [1:0]         winner_q, winner_d;
  logic [PEND_W-1:0]  pend0_q, pend0_d, pend1_q, pend1_d;
  logic               rr_q, rr_d;
  logic               clear_pend_q, clear_pend_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;

  logic frame_tick;
  logic any_pend, both_pend, in_win;
  logic dec0, dec1, flush, pick1, win_hit;
  logic acc0, acc1;
  logic drop0_c, drop1_c;

  vsync_edge_det u_edge (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .frame_tick_c (frame_tick)
  );

  assign any_pend  = (pend0_q != '0) || (pend1_q != '0);
  assign both_pend = (pend0_q != '0) && (pend1_q != '0);
  assign in_win    = (state_q == ST_WIN);

  // State, score and request-queue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      score0_q     <= '0;
      score1_q     <= '0;
      winner_q     <= WINNER_NONE;
      pend0_q      <= '0;
      pend1_q      <= '0;
      rr_q         <= 1'b0;
      clear_pend_q <= 1'b0;
      cnt_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      score0_q     <= score0_d;
      score1_q     <= score1_d;
      winner_q     <= winner_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      rr_q         <= rr_d;
      clear_pend_q <= clear_pend_d;
      cnt_q        <= cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
    end
  end

  // Next-state: frame-aligned clear, round-robin grant, win hold and pending queues.
  always_comb begin
    state_d      = state_q;
    score0_d     = score0_q;
    score1_d     = score1_q;
    winner_d     = winner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    clear_pend_d = clear_pend_q | clr_req;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    dec0         = 1'b0;
    dec1         = 1'b0;
    flush        = 1'b0;
    pick1        = 1'b0;
    win_hit      = 1'b0;

    if (frame_tick && clear_pend_q) begin
      // A deferred clear beats any grant on the same tick.
      state_d      = ST_IDLE;
      score0_d     = '0;
      score1_d     = '0;
      winner_d     = WINNER_NONE;
      rr_d         = 1'b0;
      cnt_d        = '0;
      clear_pend_d = clr_req;
      flush        = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_pend) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (frame_tick && any_pend) begin
            pick1 = both_pend ? rr_q : (pend1_q != '0);
            rr_d  = ~pick1;
            if (pick1) begin
              dec1     = 1'b1;
              gnt1_d   = 1'b1;
              score1_d = score_sat_inc(score1_q, WIN_LIM);
              if (score1_d == WIN_LIM) begin
                win_hit  = 1'b1;
                winner_d = WINNER_P1;
              end
            end else begin
              dec0     = 1'b1;
              gnt0_d   = 1'b1;
              score0_d = score_sat_inc(score0_q, WIN_LIM);
              if (score0_d == WIN_LIM) begin
                win_hit  = 1'b1;
                winner_d = WINNER_P0;
              end
            end
            if (win_hit) begin
              state_d = ST_WIN;
              cnt_d   = '0;
              flush   = 1'b1;
            end
          end else if (!any_pend) begin
            state_d = ST_IDLE;
          end
        end
        ST_WIN: begin
          if (frame_tick) begin
            if (cnt_q == HOLD_END) begin
              state_d  = ST_IDLE;
              score0_d = '0;
              score1_d = '0;
              winner_d = WINNER_NONE;
              rr_d     = 1'b0;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + HOLD_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A request is discarded in WIN, when its queue is flushed, or when full and not draining.
    drop0_c = inc0_req && (in_win || flush || ((pend0_q == PEND_LIM) && !dec0));
    drop1_c = inc1_req && (in_win || flush || ((pend1_q == PEND_LIM) && !dec1));
    acc0    = inc0_req && !drop0_c;
    acc1    = inc1_req && !drop1_c;

    if (flush)              pend0_d = '0;
    else if (acc0 && !dec0) pend0_d = pend0_q + PEND_W'(1);
    else if (dec0 && !acc0) pend0_d = pend0_q - PEND_W'(1);
    else                    pend0_d = pend0_q;

    if (flush)              pend1_d = '0;
    else if (acc1 && !dec1) pend1_d = pend1_q + PEND_W'(1);
    else if (dec1 && !acc1) pend1_d = pend1_q - PEND_W'(1);
    else                    pend1_d = pend1_q;
  end

  assign score0 = score0_q;
  assign score1 = score1_q;
  assign winner = winner_q;
  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign drop0  = drop0_c;
  assign drop1  = drop1_c;

endmodule

// File: doc/score_frame_ctrl.md
SCORE_FRAME_CTRL -- requirements
Module: score_frame_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 6, score value that ends a game.
REQ-002 SHALL have parameter HOLD_FRAMES, default 120, frames the result is held before auto-clear.
REQ-003 SHALL have parameter PEND_MAX, default 3, per-player pending-increment saturation limit.
REQ-004 SHALL have port clk, input, 1, system clock; the block uses this single clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port vsync, input, 1, VGA vertical sync, active-low, synchronous to clk.
REQ-007 SHALL have ports inc0_req and inc1_req, input, 1 each, one-cycle score-increment requests for player 0 and player 1.
REQ-008 SHALL have port clr_req, input, 1, one-cycle request to clear the game.
REQ-009 SHALL have ports score0 and score1, output, 4 each, frame-stable scores fed to the pixel generator.
REQ-010 SHALL have port winner, output, 2, winner code: 00 none, 01 player 0, 10 player 1.
REQ-011 SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle pulse when that player's increment is applied.
REQ-012 SHALL have ports drop0 and drop1, output, 1 each, one-cycle pulse when a request is discarded.

Function
REQ-013 SHALL register vsync into vsync_d; frame_tick = vsync_d AND NOT vsync, i.e. one cycle per falling edge.
REQ-014 SHALL keep per-player pending counters pend0/pend1 (2 bits) that increment on the matching inc*_req while below PEND_MAX.
REQ-015 SHALL assert drop* in the same cycle for a request at PEND_MAX, or for any request while in WIN.
REQ-016 SHALL leave a pending counter unchanged when a request arrives in the same cycle that decrements it.
REQ-017 SHALL implement states IDLE (no pending), ARMED (some pending), and WIN (result hold).
REQ-018 SHALL make the IDLE->ARMED transition when any pend is non-zero, and ARMED->IDLE when both are zero.
REQ-019 SHALL apply at most one increment per frame_tick while ARMED, with score, gnt and pend updating at that clock edge.
REQ-020 SHALL grant the player selected by round-robin pointer rr (reset 0) when both pend are non-zero, and then toggle rr.
REQ-021 SHALL grant the only pending player when just one is pending, and then set rr to the other player.
REQ-022 SHALL compare each score against WIN_SCORE so it never exceeds it, with a 4-bit unsigned result.
REQ-023 SHALL, when an applied increment makes a score equal WIN_SCORE, set winner, clear both pend, load frame counter 0, and enter WIN.
REQ-024 SHALL, while in WIN, increment the frame counter on each frame_tick and hold scores and winner constant.
REQ-025 SHALL, on the frame_tick where the frame counter equals HOLD_FRAMES-1, clear scores, winner and rr, and enter IDLE.
REQ-026 SHALL, on clr_req, set a clear_pend flag that is applied at the next frame_tick with the highest priority.
REQ-027 SHALL, when clear_pend is applied, zero scores, pend, winner, rr and clear_pend, enter IDLE, grant no increment, and pulse no gnt.
REQ-028 SHALL let score0 and score1 change only on clock edges where frame_tick=1, so no change occurs mid-frame.

Reset
REQ-029 SHALL, while rst_n=0, immediately force score0=0, score1=0, winner=00, gnt*=0, drop*=0, pend*=0, rr=0, clear_pend=0, frame counter 0, and state IDLE.
REQ-030 SHALL reset vsync_d to 1 so that no frame_tick is produced spuriously on reset release.
REQ-031 SHALL abandon the state immediately on a reset during WIN or ARMED, with no pending work surviving.

Structure
REQ-032 SHALL place the state encoding (IDLE/ARMED/WIN), the winner codes, and the WIN_SCORE/HOLD_FRAMES/PEND_MAX defaults in shared package score_ctrl_pkg.
REQ-033 SHALL implement frame_tick in a single sub-module, vsync_edge_det (register plus falling-edge pulse).
REQ-034 SHALL contain no combinational path from inputs to score0/score1/winner.

Verification
REQ-035 SHALL cover: single inc0_req mid-frame -> score0 stays 0 until next vsync fall, then score0=1 and gnt0 pulses for 1 cycle.
REQ-036 SHALL cover: inc0_req and inc1_req in the same cycle, then 2 frames -> frame 1 gives gnt0 with score0=1, frame 2 gives gnt1 with score1=1.
REQ-037 SHALL cover: 5 inc1_req in one frame -> drop1 pulses on the 4th and 5th requests, and score1 reaches 3 after 3 frames.
REQ-038 SHALL cover: score0 reaches 6 -> winner=01, inc requests cause drops, scores stay held for 120 frames, then all outputs return to 0 on tick 120.
REQ-039 SHALL cover: clr_req with pend0=2 and score1=4 -> at next tick scores=0, pend=0, with no gnt.
REQ-040 SHALL cover: rst_n pulled low mid-WIN -> outputs are zero asynchronously, and the first vsync fall after release causes no gnt.
